// File: rtl/fp_normalize.sv
// fp_normalize: two-stage normalizer for a raw single-precision adder result.
//
// Stage 1 captures the raw sign/exponent/mantissa together with the leading-zero
// count of the 25-bit mantissa. Stage 2 classifies the result (pass-through,
// zero, carry, overflow, normal, denormal), performs the shift and registers the
// normalized fields. Valid/ready handshake on both sides, one result per cycle.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       upstream handshake
//   in_sign/in_exp/in_mant  raw result (mant[24] carry-out, mant[23] hidden bit)
//   out_valid/out_ready     downstream handshake
//   out_sign/out_exp        passed sign, normalized biased exponent
//   out_frac/out_sticky     fraction without hidden bit, shifted-out OR
//   out_ovf/out_unf         overflow / underflow flags, only when the macro
//                           FP_NORMALIZE_FLAGS_EN is defined

module fp_normalize (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_exp,
    output logic [22:0] out_frac,
    output logic        out_sticky
`ifdef FP_NORMALIZE_FLAGS_EN
    ,
    output logic        out_ovf,
    output logic        out_unf
`endif
);

    typedef enum logic [2:0] {
        ClsPass,
        ClsZero,
        ClsCarry,
        ClsOvf,
        ClsNorm,
        ClsDenorm
    } cls_e;

    // Leading zeros of a 25-bit value; 25 when the value is zero.
    function automatic logic [4:0] count_lz(input logic [24:0] m);
        logic [4:0] n;
        n = 5'd25;
        for (int i = 0; i < 25; i++) begin
            if (m[i]) n = 5'(24 - i);
        end
        return n;
    endfunction

    // Stage 1 registers
    logic        s1_valid_q;
    logic        s1_sign_q;
    logic [7:0]  s1_exp_q;
    logic [24:0] s1_mant_q;
    logic [4:0]  s1_lz_q;

    // Stage 2 registers
    logic        s2_valid_q;
    logic        s2_sign_q;
    logic [7:0]  s2_exp_q;
    logic [22:0] s2_frac_q;
    logic        s2_sticky_q;

    logic        s2_en;
    logic [4:0]  in_lz;

    // Stage 2 advances when empty or when its result is being taken.
    assign s2_en    = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_en;

    always_comb begin
        in_lz = count_lz(in_mant);
    end

    // Stage 2 next-state: classification and shift
    cls_e        cls;
    logic [4:0]  norm_shift;
    logic [4:0]  den_shift;
    logic [4:0]  shamt;
    logic [22:0] shifted;
    logic [7:0]  exp_d;
    logic [22:0] frac_d;
    logic        sticky_d;

    always_comb begin
        // Only meaningful when lz >= 1 (no carry).
        norm_shift = s1_lz_q - 5'd1;
        // Only used when in_exp <= norm_shift <= 23, so the truncation is safe.
        den_shift  = (s1_exp_q == 8'd0) ? 5'd0 : 5'(s1_exp_q - 8'd1);

        if (s1_exp_q == 8'd255) begin
            cls = ClsPass;
        end else if (s1_lz_q == 5'd25) begin
            cls = ClsZero;
        end else if (s1_lz_q == 5'd0) begin
            cls = (s1_exp_q >= 8'd254) ? ClsOvf : ClsCarry;
        end else if (s1_exp_q > {3'b000, norm_shift}) begin
            cls = ClsNorm;
        end else begin
            cls = ClsDenorm;
        end

        shamt   = (cls == ClsNorm) ? norm_shift : den_shift;
        // Bits above 22 fall out of the fraction (hidden bit dropped).
        shifted = s1_mant_q[22:0] << shamt;

        exp_d    = 8'd0;
        frac_d   = 23'd0;
        sticky_d = 1'b0;
        unique case (cls)
            ClsPass: begin
                exp_d  = 8'd255;
                frac_d = s1_mant_q[22:0];
            end
            ClsZero: begin
                exp_d  = 8'd0;
                frac_d = 23'd0;
            end
            ClsCarry: begin
                exp_d    = s1_exp_q + 8'd1;
                frac_d   = s1_mant_q[23:1];
                sticky_d = s1_mant_q[0];
            end
            ClsOvf: begin
                exp_d  = 8'd255;
                frac_d = 23'd0;
            end
            ClsNorm: begin
                exp_d  = s1_exp_q - {3'b000, norm_shift};
                frac_d = shifted;
            end
            ClsDenorm: begin
                exp_d  = 8'd0;
                frac_d = shifted;
            end
            default: begin
                exp_d  = 8'd0;
                frac_d = 23'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= 8'd0;
            s1_mant_q   <= 25'd0;
            s1_lz_q     <= 5'd0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= 8'd0;
            s2_frac_q   <= 23'd0;
            s2_sticky_q <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sign_q <= in_sign;
                    s1_exp_q  <= in_exp;
                    s1_mant_q <= in_mant;
                    s1_lz_q   <= in_lz;
                end
            end
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_sign_q   <= s1_sign_q;
                    s2_exp_q    <= exp_d;
                    s2_frac_q   <= frac_d;
                    s2_sticky_q <= sticky_d;
                end
            end
        end
    end

`ifdef FP_NORMALIZE_FLAGS_EN
    logic s2_ovf_q;
    logic s2_unf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_ovf_q <= 1'b0;
            s2_unf_q <= 1'b0;
        end else if (s2_en && s1_valid_q) begin
            s2_ovf_q <= (cls == ClsOvf);
            s2_unf_q <= (cls == ClsDenorm);
        end
    end

    assign out_ovf = s2_ovf_q;
    assign out_unf = s2_unf_q;
`endif

    assign out_valid  = s2_valid_q;
    assign out_sign   = s2_sign_q;
    assign out_exp    = s2_exp_q;
    assign out_frac   = s2_frac_q;
    assign out_sticky = s2_sticky_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Testbench for fp_normalize: directed spec vectors, back-to-back stream with a
// stalling sink, randomized traffic against a behavioural model, and resets.

module tb_fp_normalize;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic        out_sticky;
`ifdef FP_NORMALIZE_FLAGS_EN
    logic        out_ovf;
    logic        out_unf;
`endif

    always #5 clk = ~clk;

    fp_normalize dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_exp    (out_exp),
        .out_frac   (out_frac),
        .out_sticky (out_sticky)
`ifdef FP_NORMALIZE_FLAGS_EN
        ,
        .out_ovf    (out_ovf),
        .out_unf    (out_unf)
`endif
    );

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic        sticky;
        logic        ovf;
        logic        unf;
    } res_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t exp_q[$];

    // Behavioural reference: find the top set bit and scale arithmetically.
    function automatic res_t ref_model(input logic sg, input logic [7:0] e,
                                       input logic [24:0] m);
        res_t   r;
        int     p;
        int     s;
        int     sh;
        longint v;
        r      = '0;
        r.sign = sg;
        if (e == 8'd255) begin
            r.exp  = 8'd255;
            r.frac = m[22:0];
        end else if (m == 25'd0) begin
            r.exp = 8'd0;
        end else if (m >= 25'h1000000) begin
            if (e >= 8'd254) begin
                r.exp = 8'd255;
                r.ovf = 1'b1;
            end else begin
                r.exp    = e + 8'd1;
                r.frac   = m[23:1];
                r.sticky = m[0];
            end
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (m[i]) p = i;
            s = 23 - p;
            if (int'(e) > s) begin
                v      = longint'(m) << s;
                r.frac = v[22:0];
                r.exp  = 8'(int'(e) - s);
            end else begin
                sh     = (e > 8'd0) ? int'(e) - 1 : 0;
                v      = longint'(m) << sh;
                r.frac = v[22:0];
                r.exp  = 8'd0;
                r.unf  = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] rand_exp();
        case ($urandom_range(0, 4))
            0:       return 8'($urandom_range(0, 4));
            1:       return 8'($urandom_range(252, 255));
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [24:0] rand_mant();
        logic [24:0] m;
        m = 25'($urandom) >> $urandom_range(0, 25);
        if ($urandom_range(0, 5) == 0) m[24] = 1'b1;
        return m;
    endfunction

    task automatic drive(input logic iv, input logic sg, input logic [7:0] e,
                         input logic [24:0] m, input logic ordy);
        in_valid  = iv;
        in_sign   = sg;
        in_exp    = e;
        in_mant   = m;
        out_ready = ordy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        // Input presented during reset must be discarded.
        drive(1'b1, 1'b1, 8'h80, 25'h1000000, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 25'h0, 1'b1);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if ({out_sign, out_exp, out_frac, out_sticky} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {out_sign, out_exp, out_frac, out_sticky});
        end
`ifdef FP_NORMALIZE_FLAGS_EN
        n_checks++;
        if ({out_ovf, out_unf} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00", {out_ovf, out_unf});
        end
`endif
        repeat (3) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_ghost: got out_valid %b expected 0", out_valid);
            end
        end
    endtask

    task automatic test_directed();
        res_t v_in[9];   // sign/exp/frac hold the input sign, exp, low mant
        logic [24:0] v_m[9];
        res_t v_x[9];
        v_in[0] = '{1'b0, 8'h80, 23'd0, 1'b0, 1'b0, 1'b0}; v_m[0] = 25'h1000000;
        v_x[0]  = '{1'b0, 8'h81, 23'h000000, 1'b0, 1'b0, 1'b0};
        v_in[1] = '{1'b0, 8'h80, 23'd0, 1'b0, 1'b0, 1'b0}; v_m[1] = 25'h0000801;
        v_x[1]  = '{1'b0, 8'h74, 23'h001000, 1'b0, 1'b0, 1'b0};
        v_in[2] = '{1'b1, 8'hFE, 23'd0, 1'b0, 1'b0, 1'b0}; v_m[2] = 25'h1800001;
        v_x[2]  = '{1'b1, 8'hFF, 23'h000000, 1'b0, 1'b1, 1'b0};
        v_in[3] = '{1'b0, 8'h03, 23'd0, 1'b0, 1'b0, 1'b0}; v_m[3] = 25'h0000100;
        v_x[3]  = '{1'b0, 8'h00, 23'h000400, 1'b0, 1'b0, 1'b1};
        v_in[4] = '{1'b1, 8'h03, 23'd0, 1'b0, 1'b0, 1'b0}; v_m[4] = 25'h0000000;
        v_x[4]  = '{1'b1, 8'h00, 23'h000000, 1'b0, 1'b0, 1'b0};
        v_in[5] = '{1'b1, 8'hFF, 23'd0, 1'b0, 1'b0, 1'b0}; v_m[5] = 25'h1ABCDEF;
        v_x[5]  = '{1'b1, 8'hFF, 23'h2BCDEF, 1'b0, 1'b0, 1'b0};
        v_in[6] = '{1'b0, 8'h10, 23'd0, 1'b0, 1'b0, 1'b0}; v_m[6] = 25'h1000003;
        v_x[6]  = '{1'b0, 8'h11, 23'h000001, 1'b1, 1'b0, 1'b0};
        v_in[7] = '{1'b0, 8'h10, 23'd0, 1'b0, 1'b0, 1'b0}; v_m[7] = 25'h0C00000;
        v_x[7]  = '{1'b0, 8'h10, 23'h400000, 1'b0, 1'b0, 1'b0};
        v_in[8] = '{1'b0, 8'h00, 23'd0, 1'b0, 1'b0, 1'b0}; v_m[8] = 25'h0000005;
        v_x[8]  = '{1'b0, 8'h00, 23'h000005, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            drive(1'b1, v_in[k].sign, v_in[k].exp, v_m[k], 1'b1);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL dir%0d_in_ready: got %b expected 1", k, in_ready);
            end
            @(negedge clk);
            drive(1'b0, 1'b0, 8'h00, 25'h0, 1'b1);
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL dir%0d_latency_early: got out_valid %b expected 0", k, out_valid);
            end
            @(negedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got out_valid %b expected 1", k, out_valid);
            end
            n_checks++;
            if ({out_sign, out_exp, out_frac, out_sticky} !==
                {v_x[k].sign, v_x[k].exp, v_x[k].frac, v_x[k].sticky}) begin
                n_fail++;
                $display("FAIL dir%0d_data: got %h expected %h", k,
                         {out_sign, out_exp, out_frac, out_sticky},
                         {v_x[k].sign, v_x[k].exp, v_x[k].frac, v_x[k].sticky});
            end
`ifdef FP_NORMALIZE_FLAGS_EN
            n_checks++;
            if ({out_ovf, out_unf} !== {v_x[k].ovf, v_x[k].unf}) begin
                n_fail++;
                $display("FAIL dir%0d_flags: got %b expected %b", k,
                         {out_ovf, out_unf}, {v_x[k].ovf, v_x[k].unf});
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic        sg[8];
        logic [7:0]  e[8];
        logic [24:0] m[8];
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        logic        ordy;
        res_t        x;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            sg[k] = 1'($urandom);
            e[k]  = rand_exp();
            m[k]  = rand_mant();
        end
        while ((sent < 8 || got < 8) && cyc < 100) begin
            @(negedge clk);
            ordy = (cyc % 2 == 0);
            if (sent < 8) drive(1'b1, sg[sent], e[sent], m[sent], ordy);
            else          drive(1'b0, 1'b0, 8'h00, 25'h0, ordy);
            #1;
            if (out_ready) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready: got %b expected 1", in_ready);
                end
            end
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected: got out_valid 1 expected no result");
                end else begin
                    x = exp_q[0];
                    // Checked every valid cycle, so stalled outputs must hold.
                    if ({out_sign, out_exp, out_frac, out_sticky} !==
                        {x.sign, x.exp, x.frac, x.sticky}) begin
                        n_fail++;
                        $display("FAIL b2b_data: got %h expected %h",
                                 {out_sign, out_exp, out_frac, out_sticky},
                                 {x.sign, x.exp, x.frac, x.sticky});
                    end
`ifdef FP_NORMALIZE_FLAGS_EN
                    n_checks++;
                    if ({out_ovf, out_unf} !== {x.ovf, x.unf}) begin
                        n_fail++;
                        $display("FAIL b2b_flags: got %b expected %b",
                                 {out_ovf, out_unf}, {x.ovf, x.unf});
                    end
`endif
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(in_sign, in_exp, in_mant));
                sent++;
            end
            cyc++;
        end
        n_checks++;
        if (got != 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results expected 8", got);
        end
    endtask

    task automatic test_random();
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        logic        pend = 1'b0;
        logic        sg;
        logic [7:0]  e;
        logic [24:0] m;
        res_t        x;
        exp_q.delete();
        while ((sent < 300 || exp_q.size() != 0) && cyc < 4000) begin
            @(negedge clk);
            if (!pend && sent < 300 && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                sg   = 1'($urandom);
                e    = rand_exp();
                m    = rand_mant();
            end
            drive(pend, sg, e, m, 1'($urandom_range(0, 9) < 7));
            #1;
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_unexpected: got out_valid 1 expected no result");
                end else begin
                    x = exp_q[0];
                    if ({out_sign, out_exp, out_frac, out_sticky} !==
                        {x.sign, x.exp, x.frac, x.sticky}) begin
                        n_fail++;
                        $display("FAIL rnd_data: got %h expected %h",
                                 {out_sign, out_exp, out_frac, out_sticky},
                                 {x.sign, x.exp, x.frac, x.sticky});
                    end
`ifdef FP_NORMALIZE_FLAGS_EN
                    n_checks++;
                    if ({out_ovf, out_unf} !== {x.ovf, x.unf}) begin
                        n_fail++;
                        $display("FAIL rnd_flags: got %b expected %b",
                                 {out_ovf, out_unf}, {x.ovf, x.unf});
                    end
`endif
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(in_sign, in_exp, in_mant));
                sent++;
                pend = 1'b0;
            end
            cyc++;
        end
        n_checks++;
        if (got != 300) begin
            n_fail++;
            $display("FAIL rnd_count: got %0d results expected 300", got);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 25'h0, 1'b1);
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h80, 25'h0000801, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h40, 25'h1000001, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 25'h0, 1'b0);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_inflight: got valid %b ready %b expected 1 0",
                     out_valid, in_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 25'h0, 1'b1);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_clear: got out_valid %b expected 0", out_valid);
        end
        repeat (5) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_ghost: got out_valid %b expected 0", out_valid);
            end
        end
        // Recovery: a fresh transaction flows normally.
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h80, 25'h1000000, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 25'h0, 1'b1);
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_exp !== 8'h81 || out_frac !== 23'd0) begin
            n_fail++;
            $display("FAIL midrst_recover: got valid %b exp %h frac %h expected 1 81 000000",
                     out_valid, out_exp, out_frac);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_normalize.md
FP_NORMALIZE -- requirements
Module: fp_normalize

Interface
REQ-001 Parameters: none; widths fixed at IEEE-754 single precision (8-bit exponent, 25-bit raw mantissa in, 23-bit fraction out).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream adder result present.
REQ-005 in_ready  output  1  block accepts input this cycle.
REQ-006 in_sign  input  1  sign of raw result.
REQ-007 in_exp  input  8  biased exponent of raw result, pre-normalization.
REQ-008 in_mant  input  25  raw magnitude; bit 24 = carry-out, bit 23 = hidden-bit position.
REQ-009 out_valid  output  1  normalized result present.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 out_sign  output  1  passed-through sign.
REQ-012 out_exp  output  8  normalized biased exponent.
REQ-013 out_frac  output  23  normalized fraction, hidden bit dropped.
REQ-014 out_sticky  output  1  OR of bits shifted out on right shift; 0 otherwise.
REQ-015 out_ovf, out_unf  output  1 each  overflow / underflow flags (present only per REQ-032).

Function
REQ-016 Two-stage pipeline: S1 registers sign, exp, mant and 5-bit leading-zero count lz of in_mant (0..25, 25 when mant==0); S2 registers shifted result.
REQ-017 Latency exactly 2 cycles from accepted input (in_valid&&in_ready) to out_valid with out_ready held 1; throughput one result per cycle.
REQ-018 Handshake: valid/ready; out_* stable while out_valid&&!out_ready; in_ready = !s1_valid || (!s2_valid || out_ready); no bubble insertion, no result dropped or duplicated.
REQ-019 Carry case (mant[24]=1): frac = mant[23:1], exp = in_exp+1, sticky = mant[0].
REQ-020 Carry with in_exp>=254: out_exp=255, out_frac=0, out_sticky=0, ovf=1 (infinity).
REQ-021 Normal case (mant[24]=0, mant!=0, s = lz-1, in_exp > s): frac = (mant<<s)[22:0], exp = in_exp-s.
REQ-022 Denormal case (mant!=0, in_exp <= s): shift by max(in_exp-1,0), out_exp=0, unf=1.
REQ-023 Zero case (mant==0): out_exp=0, out_frac=0, sticky=0, unf=0; sign passed through.
REQ-024 in_exp==255 input: passed through unchanged (exp 255, frac=mant[22:0]), no flags.
REQ-025 Flags are per-result, registered with data in S2.

Reset
REQ-026 rst_n low at rising edge clears s1_valid, s2_valid; out_valid=0 next cycle.
REQ-027 Reset values: out_sign=0, out_exp=0, out_frac=0, out_sticky=0, out_ovf=0, out_unf=0, in_ready=1 after reset.
REQ-028 Reset mid-operation discards all in-flight results; no output emitted for them.
REQ-029 Input accepted in the same cycle rst_n is low is discarded.

Configuration
REQ-030 Macro FP_NORMALIZE_FLAGS_EN controls flag ports.
REQ-031 Defined: out_ovf, out_unf ports and their S2 registers exist per REQ-020/022.
REQ-032 Undefined: ports absent; data behaviour of REQ-019..024 unchanged.

Verification
REQ-033 exp=0x80, mant=0x1000000 -> after 2 cycles exp=0x81, frac=0, sticky=0.
REQ-034 exp=0x80, mant=0x0000801 -> s=12: exp=0x74, frac=0x001000 (0x801<<12 low 23 bits = 0x001000), sticky=0.
REQ-035 exp=0xFE, mant=0x1800001 -> exp=0xFF, frac=0, ovf=1.
REQ-036 exp=0x03, mant=0x0000100 -> s=15>3: shift 2, exp=0, frac=0x000400, unf=1; mant=0 -> exp=0, frac=0.
REQ-037 Stream 8 back-to-back inputs, out_ready toggling 1010...: all 8 results in order, each matching reference model, out_* stable during stalls.
REQ-038 rst_n low for 1 cycle with 2 results in flight -> out_valid=0 next cycle, neither result ever appears.
